shift_pipe: RTL and testbench



---
 rtl/shift_pipe.sv | 120 ++++++++++++
 tb/tb_shift_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROR, one shift level per stage.
// Carries a caller tag; a single global advance stalls every stage at once.
module shift_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] M_SLL = 2'd0;
    localparam logic [1:0] M_SRL = 2'd1;
    localparam logic [1:0] M_SRA = 2'd2;
    localparam logic [1:0] M_ROR = 2'd3;

    logic                   adv;
    logic [SHW-1:0]         vld_q, vld_d;
    logic [SHW-1:0]         sg_q,  sg_d;
    logic [WIDTH-1:0]       dat_q [SHW];
    logic [WIDTH-1:0]       dat_d [SHW];
    logic [SHW-1:0]         sh_q  [SHW];
    logic [SHW-1:0]         sh_d  [SHW];
    logic [1:0]             md_q  [SHW];
    logic [1:0]             md_d  [SHW];
    logic [TAG_W-1:0]       tag_q [SHW];
    logic [TAG_W-1:0]       tag_d [SHW];

    // One shift level of 2^k; SRA fill comes from the carried sign, not the MSB.
    function automatic logic [WIDTH-1:0] level(
        input logic [WIDTH-1:0] d,
        input logic             en,
        input logic [1:0]       m,
        input logic             s,
        input int               k
    );
        logic [WIDTH-1:0] fill;
        logic [WIDTH-1:0] r;
        int               amt;
        amt  = 1 << k;
        fill = s ? ~({WIDTH{1'b1}} >> amt) : '0;
        r    = d;
        if (en) begin
            unique case (m)
                M_SLL: r = d << amt;
                M_SRL: r = d >> amt;
                M_SRA: r = (d >> amt) | fill;
                M_ROR: r = (d >> amt) | (d << (WIDTH - amt));
                default: r = d;
            endcase
        end
        return r;
    endfunction

    assign adv       = !vld_q[SHW-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[SHW-1];
    assign out_data  = dat_q[SHW-1];
    assign out_tag   = tag_q[SHW-1];

    always_comb begin
        vld_d = vld_q;
        sg_d  = sg_q;
        dat_d = dat_q;
        sh_d  = sh_q;
        md_d  = md_q;
        tag_d = tag_q;
        if (adv) begin
            vld_d[0] = in_valid;
            sg_d[0]  = in_data[WIDTH-1];
            sh_d[0]  = in_shamt;
            md_d[0]  = in_mode;
            tag_d[0] = in_tag;
            dat_d[0] = level(in_data, in_shamt[0], in_mode,
                             in_data[WIDTH-1], 0);
            for (int k = 1; k < SHW; k++) begin
                vld_d[k] = vld_q[k-1];
                sg_d[k]  = sg_q[k-1];
                sh_d[k]  = sh_q[k-1];
                md_d[k]  = md_q[k-1];
                tag_d[k] = tag_q[k-1];
                dat_d[k] = level(dat_q[k-1], sh_q[k-1][k], md_q[k-1],
                                 sg_q[k-1], k);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            sg_q  <= '0;
            for (int k = 0; k < SHW; k++) begin
                dat_q[k] <= '0;
                sh_q[k]  <= '0;
                md_q[k]  <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            sg_q  <= sg_d;
            for (int k = 0; k < SHW; k++) begin
                dat_q[k] <= dat_d[k];
                sh_q[k]  <= sh_d[k];
                md_q[k]  <= md_d[k];
                tag_q[k] <= tag_d[k];
            end
        end
    end

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: 32-bit and 8-bit instances, directed plus random traffic.
// Expected results come from a word-level shift model and a FIFO of accepted ops.
module tb_shift_pipe;

    logic        clock;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_shamt, in_tag, out_tag;
    logic [1:0]  in_mode;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data, b_out_data;
    logic [2:0]  b_in_shamt;
    logic [1:0]  b_in_mode, b_in_tag, b_out_tag;

    int tests = 0;
    int fails = 0;

    logic [31:0] q_d[$];
    logic [4:0]  q_t[$];

    shift_pipe #(.WIDTH(32), .TAG_W(5)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    shift_pipe #(.WIDTH(8), .TAG_W(2)) dut8 (
        .clock(clock), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_shamt(b_in_shamt),
        .in_mode(b_in_mode), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_tag(b_out_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] ref32(input logic [31:0] a,
                                          input int s,
                                          input logic [1:0] m);
        logic signed [31:0] sa;
        logic [63:0]        dbl;
        sa  = a;
        dbl = {a, a} >> s;
        case (m)
            2'd0:    return a << s;
            2'd1:    return a >> s;
            2'd2:    return sa >>> s;
            default: return dbl[31:0];
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", nm, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_one(input string nm, input logic [31:0] a,
                           input logic [4:0] s, input logic [1:0] m,
                           input logic [4:0] t, input logic [31:0] exp);
        int cyc;
        in_valid  = 1'b1;
        in_data   = a;
        in_shamt  = s;
        in_mode   = m;
        in_tag    = t;
        out_ready = 1'b1;
        chk({nm, "_rdy"}, {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_data  = $urandom;
        cyc      = 1;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        chk({nm, "_lat"}, cyc, 32'd5);
        chk({nm, "_dat"}, out_data, exp);
        chk({nm, "_tag"}, {27'd0, out_tag}, {27'd0, t});
        step();
    endtask

    task automatic run8(input string nm, input logic [7:0] a,
                        input logic [2:0] s, input logic [1:0] m,
                        input logic [1:0] t, input logic [7:0] exp);
        int cyc;
        b_in_valid  = 1'b1;
        b_in_data   = a;
        b_in_shamt  = s;
        b_in_mode   = m;
        b_in_tag    = t;
        b_out_ready = 1'b1;
        step();
        b_in_valid = 1'b0;
        cyc        = 1;
        while (!b_out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        chk({nm, "_lat"}, cyc, 32'd3);
        chk({nm, "_dat"}, {24'd0, b_out_data}, {24'd0, exp});
        chk({nm, "_tag"}, {30'd0, b_out_tag}, {30'd0, t});
        step();
    endtask

    initial begin
        int first, last, got, acc, drained, seen;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_shamt    = '0;
        in_mode     = '0;
        in_tag      = '0;
        out_ready   = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_in_shamt  = '0;
        b_in_mode   = '0;
        b_in_tag    = '0;
        b_out_ready = 1'b0;

        #12;
        chk("rst_ovalid", {31'd0, out_valid}, 32'd0);
        chk("rst_odata", out_data, 32'd0);
        chk("rst_otag", {27'd0, out_tag}, 32'd0);
        chk("rst_irdy", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        step();

        run_one("sra", 32'h8000_0000, 5'd4, 2'd2, 5'd7, 32'hF800_0000);
        run_one("srl", 32'h8000_0000, 5'd4, 2'd1, 5'd3, 32'h0800_0000);
        run_one("sll31", 32'h0000_0001, 5'd31, 2'd0, 5'd9, 32'h8000_0000);
        run_one("ror1", 32'h0000_0001, 5'd1, 2'd3, 5'd1, 32'h8000_0000);
        run_one("ror16", 32'h1234_5678, 5'd16, 2'd3, 5'd30, 32'h5678_1234);
        for (int m = 0; m < 4; m++)
            run_one("sh0", 32'hDEAD_BEEF, 5'd0, m[1:0], 5'd31, 32'hDEAD_BEEF);

        // back-to-back random stream with the consumer always ready
        first = -1;
        last  = -1;
        got   = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i < 20) begin
                in_valid = 1'b1;
                in_data  = (i == 3) ? 32'h7FFF_FFFF :
                           (i == 7) ? 32'hFFFF_FFFF : $urandom;
                in_shamt = (i == 3 || i == 7) ? 5'd31 : 5'($urandom_range(31));
                in_mode  = (i == 3 || i == 7) ? 2'd2 : 2'($urandom_range(3));
                in_tag   = 5'($urandom_range(31));
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                q_d.push_back(ref32(in_data, int'(in_shamt), in_mode));
                q_t.push_back(in_tag);
            end
            step();
            if (out_valid) begin
                if (first < 0) first = i;
                last = i;
                got++;
                chk("strm_pend", {31'd0, q_d.size() > 0}, 32'd1);
                if (q_d.size() > 0) begin
                    chk("strm_dat", out_data, q_d.pop_front());
                    chk("strm_tag", {27'd0, out_tag}, {27'd0, q_t.pop_front()});
                end
            end
        end
        chk("strm_first", first, 32'd4);
        chk("strm_last", last, 32'd23);
        chk("strm_cnt", got, 32'd20);

        // back-pressure: pipe fills to capacity then stalls
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_shamt = 5'($urandom_range(31));
            in_mode  = 2'($urandom_range(3));
            in_tag   = 5'($urandom_range(31));
            if (in_ready) begin
                acc++;
                q_d.push_back(ref32(in_data, int'(in_shamt), in_mode));
                q_t.push_back(in_tag);
            end
            step();
        end
        chk("bp_acc", acc, 32'd5);
        chk("bp_irdy", {31'd0, in_ready}, 32'd0);
        chk("bp_ovld", {31'd0, out_valid}, 32'd1);
        chk("bp_dat0", out_data, q_d[0]);
        step();
        step();
        chk("bp_hold", out_data, q_d[0]);
        chk("bp_htag", {27'd0, out_tag}, {27'd0, q_t[0]});
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_irdy_up", {31'd0, in_ready}, 32'd1);
        drained = 0;
        while (out_valid && drained < 10) begin
            chk("drain_dat", out_data, q_d.pop_front());
            chk("drain_tag", {27'd0, out_tag}, {27'd0, q_t.pop_front()});
            step();
            drained++;
        end
        chk("drain_cnt", drained, 32'd5);

        // asynchronous reset with three ops in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom | 32'h1;
            in_shamt = 5'($urandom_range(31));
            in_mode  = 2'($urandom_range(3));
            in_tag   = 5'($urandom_range(1, 31));
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        chk("ar_pre", {31'd0, out_valid}, 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_ovld", {31'd0, out_valid}, 32'd0);
        chk("ar_odat", out_data, 32'd0);
        chk("ar_otag", {27'd0, out_tag}, 32'd0);
        chk("ar_irdy", {31'd0, in_ready}, 32'd1);
        #2;
        reset = 1'b0;
        step();
        chk("ar_irdy2", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) seen++;
        end
        chk("ar_ghost", seen, 32'd0);
        run_one("ar_new", 32'hC000_0003, 5'd2, 2'd3, 5'd12, 32'hF000_0000);

        run8("w8_sra", 8'h90, 3'd3, 2'd2, 2'd1, 8'hF2);
        run8("w8_ror", 8'h81, 3'd7, 2'd3, 2'd2, 8'h03);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
